// File: rtl/cheat_code_loader.sv
// Cheat-code loader: assembles four 32-bit host words into one 129-bit matcher code
// and strobes it, tracking loaded-code count, overflow and the matcher clear pulse.
module cheat_code_loader #(
  parameter int unsigned MAX_CODES   = 32,
  parameter int unsigned STROBE_HOLD = 4,
  parameter bit          BYTE_SWAP   = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         wr_valid,
  input  logic [31:0]                  wr_data,
  output logic                         wr_ready,
  output logic [128:0]                 code,
  output logic                         codes_reset,
  output logic [$clog2(MAX_CODES):0]   code_count,
  output logic                         overflow,
  output logic                         busy
);

  localparam int unsigned CNT_W  = $clog2(MAX_CODES) + 1;
  localparam int unsigned HOLD_W = (STROBE_HOLD > 1) ? $clog2(STROBE_HOLD) : 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_COLLECT,
    S_STROBE_HI,
    S_STROBE_LO
  } state_t;

  state_t              r_state, w_state;
  logic [1:0]          r_word_idx, w_word_idx;
  logic [95:0]         r_asm, w_asm;
  logic [128:0]        r_code, w_code;
  logic [CNT_W-1:0]    r_count, w_count;
  logic                r_overflow, w_overflow;
  logic                r_codes_reset, w_codes_reset;
  logic [HOLD_W-1:0]   r_hold, w_hold;
  logic [31:0]         w_word;
  logic                w_xfer;
  logic                w_hold_last;

  // Host words arrive little-endian; the matcher expects big-endian fields.
  generate
    if (BYTE_SWAP) begin : g_swap
      assign w_word = {wr_data[7:0], wr_data[15:8], wr_data[23:16], wr_data[31:24]};
    end else begin : g_noswap
      assign w_word = wr_data;
    end
  endgenerate

  assign wr_ready    = (r_state == S_COLLECT) & ~clear;
  assign w_xfer      = wr_valid & wr_ready;
  assign w_hold_last = (r_hold == HOLD_W'(STROBE_HOLD - 1));

  assign code        = r_code;
  assign codes_reset = r_codes_reset;
  assign code_count  = r_count;
  assign overflow    = r_overflow;
  assign busy        = (r_word_idx != 2'd0) | (r_state == S_STROBE_HI) | (r_state == S_STROBE_LO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_INIT;
      r_word_idx    <= 2'd0;
      r_asm         <= '0;
      r_code        <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_codes_reset <= 1'b0;
      r_hold        <= '0;
    end else begin
      r_state       <= w_state;
      r_word_idx    <= w_word_idx;
      r_asm         <= w_asm;
      r_code        <= w_code;
      r_count       <= w_count;
      r_overflow    <= w_overflow;
      r_codes_reset <= w_codes_reset;
      r_hold        <= w_hold;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_word_idx    = r_word_idx;
    w_asm         = r_asm;
    w_code        = r_code;
    w_count       = r_count;
    w_overflow    = r_overflow;
    w_codes_reset = 1'b0;
    w_hold        = r_hold;

    case (r_state)
      S_INIT: w_state = S_COLLECT;

      S_COLLECT: begin
        if (w_xfer) begin
          w_word_idx = r_word_idx + 2'd1;
          case (r_word_idx)
            2'd0:    w_asm[95:64] = w_word;
            2'd1:    w_asm[63:32] = w_word;
            2'd2:    w_asm[31:0]  = w_word;
            default: begin
              // Final word: payload and strobe launch together on this edge.
              if (r_count < CNT_W'(MAX_CODES)) begin
                w_code  = {1'b1, r_asm, w_word};
                w_count = r_count + CNT_W'(1);
                w_hold  = '0;
                w_state = S_STROBE_HI;
              end else begin
                w_overflow = 1'b1;
              end
            end
          endcase
        end
      end

      S_STROBE_HI: begin
        if (w_hold_last) begin
          w_code[128] = 1'b0;
          w_hold      = '0;
          w_state     = S_STROBE_LO;
        end else begin
          w_hold = r_hold + HOLD_W'(1);
        end
      end

      S_STROBE_LO: begin
        if (w_hold_last) begin
          w_hold  = '0;
          w_state = S_COLLECT;
        end else begin
          w_hold = r_hold + HOLD_W'(1);
        end
      end

      default: w_state = S_INIT;
    endcase

    // Clear wins over everything once out of INIT.
    if (clear && (r_state != S_INIT)) begin
      w_code        = '0;
      w_word_idx    = 2'd0;
      w_count       = '0;
      w_overflow    = 1'b0;
      w_hold        = '0;
      w_state       = S_COLLECT;
      w_codes_reset = 1'b1;
    end
  end

endmodule
